mem_access_stage: RTL

Memory-stage responder that consumes the ALU-to-MEM pipeline control/data signals and executes them. Non-memory instructions pass straight through to a registered MEM/WB writeback output. Loads and stores drive a request/acknowledge handshake to the data memory, stall the upstream pipeline until the access completes, and abort on a bounded timeout. The block sits between the ALU_to_MEM pipeline register and the writeback stage.

---
 rtl/mem_access_if.sv | 29 ++
 rtl/mem_access_stage.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface mem_access_if #(
  parameter int unsigned DATA_W = 24
);
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage: passes ALU results to MEM/WB, runs loads/stores over a req/ack bus with a
// bounded timeout, and stalls upstream while an access is outstanding.
module mem_access_stage #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              writeback_enable,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] write_data,
  mem_access_if.master      mem,
  output logic              stall,
  output logic              writeback_enable_out,
  output logic [DATA_W-1:0] writeback_data_out,
  output logic              mem_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_cap_q, wb_cap_d;
  logic              wb_en_q, wb_en_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wb_cap_d  = wb_cap_q;
    wb_en_d   = 1'b0;
    wb_data_d = wb_data_q;
    err_d     = 1'b0;
    stall     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_read_enable && mem_write_enable) begin
          err_d = 1'b1;
        end else if (mem_read_enable || mem_write_enable) begin
          stall    = 1'b1;
          state_d  = StAccess;
          addr_d   = alu_result;
          wdata_d  = write_data;
          we_d     = mem_write_enable;
          wb_cap_d = writeback_enable;
          req_d    = 1'b1;
          cnt_d    = CntW'(1);
        end else begin
          wb_en_d   = writeback_enable;
          wb_data_d = alu_result;
        end
      end
      StAccess: begin
        if (mem.mem_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          cnt_d   = '0;
          if (!we_q) begin
            wb_en_d   = wb_cap_q;
            wb_data_d = mem.mem_rdata;
          end
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          // Instruction is dropped: release upstream in the same cycle the error is decided.
          state_d = StIdle;
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wb_cap_q  <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wb_cap_q  <= wb_cap_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign mem.mem_req           = req_q;
  assign mem.mem_we            = we_q;
  assign mem.mem_addr          = addr_q;
  assign mem.mem_wdata         = wdata_q;
  assign writeback_enable_out  = wb_en_q;
  assign writeback_data_out    = wb_data_q;
  assign mem_error             = err_q;

endmodule
